// File: rtl/demux_1_16_tdm.sv
// demux_1_16_tdm: serial-to-parallel TDM demultiplexer, the receiving end of a
// WIDTH:1 mux-based serialiser.
//
// After frame_start, each valid serial bit is written into slot S of a shadow
// register, with S counting 0..WIDTH-1. Slot k lands in Y[k]. When the last
// slot is filled, the word is published on Y with a one-cycle Y_valid pulse.
//
// Optional feature, enabled by defining the macro DEMUX_PARITY_EN:
//   after slot WIDTH-1 the next valid beat is an even-parity bit over the word.
//   Y/Y_valid update on that beat, and parity_err pulses alongside Y_valid when
//   the parity does not match. Without the macro parity_err is constant 0.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset; discards any partial word
//   frame_start begins a frame; the same-cycle din/din_valid is the slot-0 beat
//   din         serial data bit
//   din_valid   din is sampled this cycle
//   S           slot index the next valid beat will be written to
//   Y           last completed word, held until the next completion
//   Y_valid     one-cycle pulse when Y updates
//   busy        high while a frame is being collected
//   frame_err   one-cycle pulse when a frame in progress is aborted
//   parity_err  one-cycle parity failure pulse (parity build only)
module demux_1_16_tdm #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SEL_W      = 4,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             din,
  input  logic             din_valid,
  output logic [SEL_W-1:0] S,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  typedef enum logic [1:0] {StIdle, StCollect, StParity} state_e;

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               parity_err_q, parity_err_d;

  logic               done;
  logic [WIDTH-1:0]   done_word;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    y_d          = y_q;
    y_valid_d    = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    done         = 1'b0;
    done_word    = {din, shadow_q[WIDTH-2:0]};

    case (state_q)
      StIdle: begin
        // Valid beats without frame_start are ignored here.
        if (frame_start) begin
          shadow_d    = '0;
          shadow_d[0] = din & din_valid;
          sel_d       = din_valid ? SEL_W'(1) : '0;
          state_d     = StCollect;
        end
      end

      StCollect, StParity: begin
        if (frame_start) begin
          // Restart; only a frame that already holds data counts as aborted.
          // In the parity state S reads WIDTH-1, so it always flags.
          frame_err_d = (sel_q != '0);
          shadow_d    = '0;
          shadow_d[0] = din & din_valid;
          sel_d       = din_valid ? SEL_W'(1) : '0;
          state_d     = StCollect;
        end else if (din_valid) begin
`ifdef DEMUX_PARITY_EN
          if (state_q == StParity) begin
            done         = 1'b1;
            done_word    = shadow_q;
            parity_err_d = (^shadow_q) ^ din;
          end else if (sel_q == LastSlot) begin
            // Hold S at WIDTH-1 while waiting for the parity beat.
            shadow_d[WIDTH-1] = din;
            state_d           = StParity;
          end else begin
            shadow_d[sel_q] = din;
            sel_d           = sel_q + SEL_W'(1);
          end
`else
          if (sel_q == LastSlot) begin
            done = 1'b1;
          end else begin
            shadow_d[sel_q] = din;
            sel_d           = sel_q + SEL_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d = StIdle;
        sel_d   = '0;
      end
    endcase

    if (done) begin
      y_d       = done_word;
      y_valid_d = 1'b1;
      sel_d     = '0;
      state_d   = CONTINUOUS ? StCollect : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      shadow_q     <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign S          = sel_q;
  assign Y          = y_q;
  assign Y_valid    = y_valid_q;
  assign busy       = (state_q != StIdle);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_demux_1_16_tdm.sv
// Self-checking bench for demux_1_16_tdm: directed steps plus randomised frames.
// The reference is the word handed to the stimulus: whatever goes in LSB-first
// must come out on Y, with event counts for Y_valid / frame_err / parity_err.
module tb_demux_1_16_tdm;

  localparam int W = 16;
`ifdef DEMUX_PARITY_EN
  localparam int Spacing = W + 1;
`else
  localparam int Spacing = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         fs, din, dv;
  logic [3:0]   s;
  logic [W-1:0] y;
  logic         yv, busy, fe, pe;

  logic         fs1, din1, dv1;
  logic [3:0]   s1;
  logic [W-1:0] y1;
  logic         yv1, busy1, fe1, pe1;

  demux_1_16_tdm #(.WIDTH(W), .SEL_W(4), .CONTINUOUS(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(fs), .din(din), .din_valid(dv),
    .S(s), .Y(y), .Y_valid(yv), .busy(busy), .frame_err(fe), .parity_err(pe)
  );

  demux_1_16_tdm #(.WIDTH(W), .SEL_W(4), .CONTINUOUS(1'b1)) u_dut_cont (
    .clk(clk), .rst_n(rst_n), .frame_start(fs1), .din(din1), .din_valid(dv1),
    .S(s1), .Y(y1), .Y_valid(yv1), .busy(busy1), .frame_err(fe1), .parity_err(pe1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int yv_cnt = 0, fe_cnt = 0, pe_cnt = 0, both_cnt = 0, fe1_cnt = 0;
  int yv1_t[$];
  logic [W-1:0] yv1_w[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (yv) yv_cnt++;
    if (fe) fe_cnt++;
    if (pe) pe_cnt++;
    if (yv && fe) both_cnt++;
    if (fe1) fe1_cnt++;
    if (yv1) begin
      yv1_t.push_back(cyc);
      yv1_w.push_back(y1);
    end
  endtask

  task automatic beat(input bit f, input bit d);
    fs = f; dv = 1'b1; din = d;
    step();
    fs = 1'b0; dv = 1'b0; din = 1'b0;
  endtask

  // mode 0: back-to-back, 1: 3-cycle gaps after slots 4 and 11, 2: random gaps
  task automatic send_data(input logic [W-1:0] w, input int mode);
    for (int k = 0; k < W; k++) begin
      beat(k == 0, w[k]);
      if (mode == 1 && (k == 4 || k == 11)) begin
        repeat (3) step();
        chk("gap_hold_S", s, k + 1);
      end else if (mode == 2 && k != W - 1) begin
        repeat ($urandom_range(0, 2)) step();
      end
    end
  endtask

  // Full frame on the non-continuous DUT, then completion checks.
  task automatic frame(input logic [W-1:0] w, input int mode);
    int n0;
    n0 = yv_cnt;
    send_data(w, mode);
`ifdef DEMUX_PARITY_EN
    chk("pre_parity_S", s, W - 1);
    chk("pre_parity_yv", yv, 0);
    beat(1'b0, ^w);
    chk("frame_pe", pe, 0);
`endif
    chk("frame_yv", yv, 1);
    chk("frame_Y", y, w);
    chk("frame_busy", busy, 0);
    chk("frame_S", s, 0);
    chk("frame_yv_count", yv_cnt, n0 + 1);
    step();
    chk("frame_yv_pulse", yv, 0);
    chk("frame_Y_hold", y, w);
  endtask

  logic [W-1:0] wa, wb, wr;
  int n_yv, n_fe, k_part;
  bit ab;

  initial begin
    rst_n = 1'b0;
    fs = 0; din = 0; dv = 0;
    fs1 = 0; din1 = 0; dv1 = 0;
    step(); step();
    chk("rst_S", s, 0);
    chk("rst_busy", busy, 0);
    chk("rst_Y", y, 0);
    chk("rst_yv", yv, 0);
    chk("rst_fe", fe, 0);
    chk("rst_pe", pe, 0);
    rst_n = 1'b1;
    step();

    // Reset mid-frame discards the partial word.
    wa = 16'hFFFF;
    for (int k = 0; k < 7; k++) beat(k == 0, wa[k]);
    chk("mid_S", s, 7);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_S", s, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_Y", y, 0);
    chk("midrst_yv_count", yv_cnt, 0);
    frame(16'h5A3C, 0);

    // Basic and gapped frames.
    frame(16'hA5C3, 0);
    // Valid beats in idle are ignored.
    beat(1'b0, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b0);
    chk("idle_ignore_S", s, 0);
    chk("idle_ignore_busy", busy, 0);
    chk("idle_ignore_Y", y, 16'hA5C3);
    frame(16'hA5C3, 1);

    // Abort after 9 beats, then a full word, from a freshly reset Y.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_yv = yv_cnt; n_fe = fe_cnt;
    wa = 16'hFFFF;
    for (int k = 0; k < 9; k++) beat(k == 0, wa[k]);
    wb = 16'h00FF;
    beat(1'b1, wb[0]);
    chk("abort_fe", fe, 1);
    chk("abort_S", s, 1);
    chk("abort_Y", y, 0);
    for (int k = 1; k < W; k++) beat(1'b0, wb[k]);
`ifdef DEMUX_PARITY_EN
    beat(1'b0, ^wb);
`endif
    chk("abort_Y_new", y, 16'h00FF);
    chk("abort_fe_count", fe_cnt, n_fe + 1);
    chk("abort_yv_count", yv_cnt, n_yv + 1);

    // frame_start while collecting at S==0 restarts without an error.
    n_fe = fe_cnt;
    fs = 1'b1; dv = 1'b0; step();
    chk("fs_nodata_S", s, 0);
    chk("fs_nodata_busy", busy, 1);
    step();
    fs = 1'b0;
    frame(16'h8001, 0);
    chk("s0_restart_no_fe", fe_cnt, n_fe);

    // Randomised frames, some preceded by a partial frame that gets aborted.
    for (int i = 0; i < 12; i++) begin
      wr = W'($urandom);
      ab = 1'($urandom_range(0, 1));
      n_fe = fe_cnt;
      if (ab) begin
        k_part = $urandom_range(1, W - 1);
        for (int k = 0; k < k_part; k++) beat(k == 0, 1'($urandom));
      end
      frame(wr, 2);
      chk("rand_fe_count", fe_cnt, n_fe + (ab ? 1 : 0));
    end

`ifdef DEMUX_PARITY_EN
    // Even parity: 16'h0001 needs parity bit 1.
    n_yv = pe_cnt;
    send_data(16'h0001, 0);
    beat(1'b0, 1'b1);
    chk("par_ok_yv", yv, 1);
    chk("par_ok_pe", pe, 0);
    send_data(16'h0001, 0);
    beat(1'b0, 1'b0);
    chk("par_bad_yv", yv, 1);
    chk("par_bad_pe", pe, 1);
    chk("par_bad_Y", y, 16'h0001);
    chk("par_pe_count", pe_cnt, n_yv + 1);
`endif

    // Continuous mode: one frame_start, two words back to back.
    wa = 16'h1234;
    wb = 16'hFFFF;
    for (int i = 0; i < 2 * W; i++) begin
      fs1 = (i == 0); dv1 = 1'b1;
      din1 = (i < W) ? wa[i] : wb[i - W];
      step();
      chk("cont_busy", busy1, 1);
`ifdef DEMUX_PARITY_EN
      if (i == W - 1 || i == 2 * W - 1) begin
        fs1 = 1'b0;
        din1 = (i == W - 1) ? ^wa : ^wb;
        step();
        chk("cont_busy_par", busy1, 1);
      end
`endif
    end
    fs1 = 1'b0; dv1 = 1'b0; din1 = 1'b0;
    step();
    chk("cont_busy_after", busy1, 1);
    chk("cont_S_after", s1, 0);
    chk("cont_yv_count", yv1_t.size(), 2);
    if (yv1_t.size() == 2) begin
      chk("cont_spacing", yv1_t[1] - yv1_t[0], Spacing);
      chk("cont_word0", yv1_w[0], 16'h1234);
      chk("cont_word1", yv1_w[1], 16'hFFFF);
    end
    chk("cont_fe_count", fe1_cnt, 0);

    chk("yv_fe_exclusive", both_cnt, 0);
`ifndef DEMUX_PARITY_EN
    chk("pe_never", pe_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1_16_tdm.md
Name: demux_1_16_tdm

Overview:
- Serial-to-parallel time-division demultiplexer: receiver end of a 16:1 mux-based serialiser.
- After a frame-start strobe, it steers each valid serial bit into slot S of a 16-bit shadow register, with S counting 0..15.
- When all slots are filled, the word is published on a registered parallel output with a one-cycle valid pulse.
- Sits downstream of the mux tree / serial link, feeding parallel consumers.

Parameters:
- WIDTH, 16, number of slots and width of the parallel output; must be a power of two, at least 2.
- SEL_W, 4, slot index width; must equal log2(WIDTH).
- CONTINUOUS, 0
  - 0: return to IDLE after each word.
  - 1: start the next frame immediately at slot 0, without a frame_start.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- frame_start  input  1  begins a frame; the same-cycle din/din_valid is the slot-0 beat.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on this cycle.
- S  output  SEL_W  slot index the next valid beat will be written to.
- Y  output  WIDTH  last completed word; holds until the next completion.
- Y_valid  output  1  one-cycle pulse when Y updates.
- busy  output  1  high while in COLLECT (or PARITY).
- frame_err  output  1  one-cycle pulse when a frame is aborted by a new frame_start.
- parity_err  output  1  see Optional Feature; constant 0 when the feature is compiled out.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge), applies even mid-frame; the partial word is discarded:
  - S=0, Y=0, Y_valid=0, busy=0, frame_err=0, parity_err=0, shadow=0, state=IDLE.
- States: IDLE, COLLECT, and PARITY (PARITY only with the macro).
- IDLE:
  - frame_start=1 & din_valid=1: shadow[0]<=din, S<=1, go to COLLECT.
  - frame_start=1 & din_valid=0: S<=0, go to COLLECT.
  - din_valid without frame_start is ignored.
- COLLECT, din_valid=1 without frame_start: shadow[S]<=din, S<=S+1 (wraps at WIDTH).
- Completion: on the beat where S==WIDTH-1:
  - Y<={din, shadow[WIDTH-2:0]} and Y_valid=1 on the next cycle. Latency is 1 clk from the last beat to Y_valid.
  - S wraps to 0.
  - CONTINUOUS=0: go to IDLE. CONTINUOUS=1: stay in COLLECT.
- din_valid=0 holds state, S and shadow; there is no timeout.
- frame_start in COLLECT with S!=0: frame_err pulse next cycle, shadow cleared, restart at slot 0, and the current beat is taken as slot 0 if din_valid=1. Y is not updated.
- frame_start in COLLECT with S==0 restarts without frame_err.
- Bit ordering: slot k maps to Y[k], the inverse of select value k on the serialiser mux.
- Y_valid and frame_err never assert in the same cycle.
- busy=1 exactly while state!=IDLE.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - After slot WIDTH-1 the FSM enters PARITY instead of completing the word.
  - The next valid beat is an even-parity bit over the WIDTH data bits.
  - On that beat, Y and Y_valid update (latency 1 clk from the parity beat).
  - parity_err pulses in the same cycle as Y_valid if (^word)^din != 0. Y still updates.
  - frame_start during PARITY is an abort (frame_err).
  - S reads WIDTH-1 while in PARITY.
- Undefined: no PARITY state; parity_err is tied to 0.

Test Plan:
- Reset mid-frame: feed 7 beats, pull rst_n low for 1 clk -> S=0, busy=0, Y=16'h0000, no Y_valid; next frame completes normally.
- Basic frame: frame_start plus 16 consecutive beats carrying 16'hA5C3 LSB-first -> Y=16'hA5C3 with Y_valid one clk after the 16th beat; busy drops; S=0.
- Gapped input: the same word with din_valid low for 3 clks after slots 4 and 11 -> identical Y=16'hA5C3; S holds during the gaps.
- Abort: frame_start again after 9 beats, then a full word 16'h00FF -> frame_err pulse once, Y goes directly 16'h0000 -> 16'h00FF, single Y_valid.
- CONTINUOUS=1: one frame_start, then 32 beats of 16'h1234 then 16'hFFFF -> two Y_valid pulses 16 clks apart, busy stays 1.
- DEMUX_PARITY_EN: word 16'h0001 with parity bit 1 -> Y_valid, parity_err=0; parity bit 0 -> Y=16'h0001, parity_err=1.
